// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencer: FSM state encoding and page width.
package branch_pkg;

    localparam int PAGE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } branch_state_t;

endpackage

// File: rtl/branch_seq_if.sv
// Request/result bundle between a branch requester (master) and branch_seq (slave).
interface branch_seq_if #(
    parameter int ADDR_W = 16
);

    logic              branch_req;
    logic [7:0]        offset;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] target_pc;
    logic              busy;
    logic              done;
    logic              page_cross;
    logic              dir_fwd;
    logic              dir_bwd;

    modport master (
        output branch_req, offset, pc_in,
        input  target_pc, busy, done, page_cross, dir_fwd, dir_bwd
    );

    modport slave (
        input  branch_req, offset, pc_in,
        output target_pc, busy, done, page_cross, dir_fwd, dir_bwd
    );

endinterface

// File: rtl/flag_bank.sv
// Bank of NUM_CH captured flags; loads on enable while the global hold (enable_ffs) is released.
module flag_bank #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              enable_ffs,
    input  logic [NUM_CH-1:0] d,
    output logic [NUM_CH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (enable_ffs && enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_seq.sv
// Branch target sequencer: 8-bit page add with high-part fixup, plus a captured flag bank.
// Define BRANCH_SEQ_PAGE_PENALTY_EN to spend an extra FIX cycle on page crossings.
//
//   state | meaning
//   IDLE  | waiting for branch_req; latches pc_in/offset
//   ADD   | low-byte add, direction and page-cross detect
//   FIX   | high-part increment/decrement after a page cross
//   DONE  | one-cycle done pulse, then back to IDLE
module branch_seq
    import branch_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_ffs,
    input  logic              enable,
    input  logic [NUM_CH-1:0] flag_in,
    output logic [NUM_CH-1:0] flag_out,
    branch_seq_if.slave       bus
);

    localparam int HI_W = ADDR_W - PAGE_W;

    branch_state_t     stateQ, stateD;
    logic [ADDR_W-1:0] pcQ, pcD;
    logic [7:0]        offQ, offD;
    logic [ADDR_W-1:0] targetQ, targetD;
    logic              busyQ, busyD;
    logic              doneQ, doneD;
    logic              crossQ, crossD;
    logic              fwdQ, fwdD;
    logic              bwdQ, bwdD;

    logic [PAGE_W:0]   sumLo;
    logic [HI_W-1:0]   hiCur;
    logic [HI_W-1:0]   hiFix;
    logic              isBwd;
    logic              crossNow;

    flag_bank #(
        .NUM_CH(NUM_CH)
    ) u_flag_bank (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .enable_ffs(enable_ffs),
        .d         (flag_in),
        .q         (flag_out)
    );

    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        offD     = offQ;
        targetD  = targetQ;
        busyD    = busyQ;
        doneD    = doneQ;
        crossD   = crossQ;
        fwdD     = fwdQ;
        bwdD     = bwdQ;

        sumLo    = {1'b0, pcQ[PAGE_W-1:0]} + {1'b0, offQ};
        isBwd    = offQ[7];
        // A backward displacement stays in-page exactly when the 8-bit add carries.
        crossNow = isBwd ? ~sumLo[PAGE_W] : sumLo[PAGE_W];
        hiCur    = pcQ[ADDR_W-1:PAGE_W];
        hiFix    = isBwd ? (hiCur - HI_W'(1)) : (hiCur + HI_W'(1));

        case (stateQ)
            IDLE: begin
                if (bus.branch_req) begin
                    pcD    = bus.pc_in;
                    offD   = bus.offset;
                    busyD  = 1'b1;
                    stateD = ADD;
                end
            end
            ADD: begin
                targetD[PAGE_W-1:0] = sumLo[PAGE_W-1:0];
                crossD              = crossNow;
                fwdD                = ~isBwd;
                bwdD                = isBwd;
`ifdef BRANCH_SEQ_PAGE_PENALTY_EN
                targetD[ADDR_W-1:PAGE_W] = hiCur;
                if (crossNow) begin
                    stateD = FIX;
                end else begin
                    busyD  = 1'b0;
                    doneD  = 1'b1;
                    stateD = DONE;
                end
`else
                targetD[ADDR_W-1:PAGE_W] = crossNow ? hiFix : hiCur;
                busyD  = 1'b0;
                doneD  = 1'b1;
                stateD = DONE;
`endif
            end
            FIX: begin
                targetD[ADDR_W-1:PAGE_W] = hiFix;
                busyD  = 1'b0;
                doneD  = 1'b1;
                stateD = DONE;
            end
            DONE: begin
                doneD  = 1'b0;
                stateD = IDLE;
            end
            default: begin
                busyD  = 1'b0;
                doneD  = 1'b0;
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            pcQ     <= '0;
            offQ    <= '0;
            targetQ <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            crossQ  <= 1'b0;
            fwdQ    <= 1'b0;
            bwdQ    <= 1'b0;
        end else if (enable_ffs) begin
            stateQ  <= stateD;
            pcQ     <= pcD;
            offQ    <= offD;
            targetQ <= targetD;
            busyQ   <= busyD;
            doneQ   <= doneD;
            crossQ  <= crossD;
            fwdQ    <= fwdD;
            bwdQ    <= bwdD;
        end
    end

    assign bus.target_pc  = targetQ;
    assign bus.busy       = busyQ;
    assign bus.done       = doneQ;
    assign bus.page_cross = crossQ;
    assign bus.dir_fwd    = fwdQ;
    assign bus.dir_bwd    = bwdQ;

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: directed and random branches against an arithmetic model.
module tb_branch_seq;

`ifdef BRANCH_SEQ_PAGE_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       enableFfs;
    logic       enable;
    logic [1:0] flagIn;
    logic [1:0] flagOut;

    int         nVec;
    int         nMis;
    logic [15:0] prevT;
    logic [1:0]  flagModel;

    branch_seq_if #(.ADDR_W(16)) busIf ();

    branch_seq #(
        .NUM_CH(2),
        .ADDR_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_ffs(enableFfs),
        .enable    (enable),
        .flag_in   (flagIn),
        .flag_out  (flagOut),
        .bus       (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One branch from IDLE; optional freeze in the last busy state and/or frozen done.
    task automatic runBranch(input logic [15:0] pc, input logic [7:0] off,
                             input int freezeLen, input bit pokeReq, input int doneHold);
        logic [15:0] expT;
        bit          expCross;
        bit          expFwd;
        int          baseLat;
        int          lat;
        bit          froze;
        expT     = pc + {{8{off[7]}}, off};
        expCross = (expT[15:8] != pc[15:8]);
        expFwd   = ($signed(off) >= 0);
        baseLat  = (expCross && PEN) ? 3 : 2;
        froze    = 1'b0;

        busIf.branch_req = 1'b1;
        busIf.pc_in      = pc;
        busIf.offset     = off;
        tick();
        lat = 1;
        busIf.branch_req = pokeReq;
        busIf.pc_in      = 16'($urandom);
        busIf.offset     = 8'($urandom);
        chk("busy_after_req", {31'd0, busIf.busy}, 32'd1);

        while (busIf.done !== 1'b1 && lat < 20) begin
            if (freezeLen > 0 && !froze && lat == baseLat - 1) begin
                froze = 1'b1;
                enableFfs = 1'b0;
                for (int i = 0; i < freezeLen; i++) begin
                    tick();
                    lat++;
                    chk("frz_busy", {31'd0, busIf.busy}, 32'd1);
                    chk("frz_done", {31'd0, busIf.done}, 32'd0);
                    if (baseLat == 2) chk("frz_target", {16'd0, busIf.target_pc}, {16'd0, prevT});
                end
                enableFfs = 1'b1;
            end
            tick();
            lat++;
        end
        busIf.branch_req = 1'b0;

        chk("latency", lat, baseLat + freezeLen);
        chk("target_pc", {16'd0, busIf.target_pc}, {16'd0, expT});
        chk("page_cross", {31'd0, busIf.page_cross}, {31'd0, expCross});
        chk("dir_fwd", {31'd0, busIf.dir_fwd}, {31'd0, expFwd});
        chk("dir_bwd", {31'd0, busIf.dir_bwd}, {31'd0, ~expFwd});
        chk("busy_at_done", {31'd0, busIf.busy}, 32'd0);
        prevT = expT;

        if (doneHold > 0) begin
            enableFfs = 1'b0;
            for (int i = 0; i < doneHold; i++) begin
                tick();
                chk("done_frozen", {31'd0, busIf.done}, 32'd1);
            end
            enableFfs = 1'b1;
        end

        tick();
        chk("done_one_cycle", {31'd0, busIf.done}, 32'd0);
        chk("no_requeue", {31'd0, busIf.busy}, 32'd0);
        chk("target_hold", {16'd0, busIf.target_pc}, {16'd0, expT});
        tick();
        chk("idle_done", {31'd0, busIf.done}, 32'd0);
    endtask

    initial begin
        nVec = 0;
        nMis = 0;
        rst = 1'b1;
        enableFfs = 1'b1;
        enable = 1'b0;
        flagIn = 2'b00;
        busIf.branch_req = 1'b0;
        busIf.pc_in = '0;
        busIf.offset = '0;
        flagModel = 2'b00;
        prevT = 16'h0000;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_target", {16'd0, busIf.target_pc}, 32'd0);
        chk("rst_busy", {31'd0, busIf.busy}, 32'd0);
        chk("rst_done", {31'd0, busIf.done}, 32'd0);
        chk("rst_flags", {30'd0, flagOut}, 32'd0);

        runBranch(16'h1234, 8'h10, 0, 1'b0, 0);
        runBranch(16'h12F0, 8'h20, 0, 1'b0, 0);
        runBranch(16'h1205, 8'hF0, 0, 1'b0, 0);
        runBranch(16'hFFF0, 8'h20, 0, 1'b0, 0);
        runBranch(16'h0005, 8'hF0, 0, 1'b0, 0);
        runBranch(16'h1234, 8'h00, 0, 1'b0, 0);
        runBranch(16'h1234, 8'hF0, 0, 1'b1, 0);
        runBranch(16'h12F0, 8'h20, 3, 1'b0, 0);
        runBranch(16'h1234, 8'h10, 3, 1'b1, 2);

        // Flag bank: hold while frozen, capture while enabled.
        enable = 1'b1;
        enableFfs = 1'b0;
        flagIn = 2'b11;
        tick();
        chk("flag_frozen", {30'd0, flagOut}, {30'd0, flagModel});
        enableFfs = 1'b1;
        flagIn = 2'b10;
        tick();
        flagModel = 2'b10;
        chk("flag_capture", {30'd0, flagOut}, {30'd0, flagModel});
        for (int i = 0; i < 20; i++) begin
            enable = 1'($urandom);
            enableFfs = 1'($urandom);
            flagIn = 2'($urandom);
            tick();
            if (enable && enableFfs) flagModel = flagIn;
            chk("flag_rand", {30'd0, flagOut}, {30'd0, flagModel});
        end
        enable = 1'b0;
        enableFfs = 1'b1;
        tick();
        tick();

        // Reset in ADD with a request pending on the reset edge.
        flagIn = 2'b01;
        enable = 1'b1;
        busIf.branch_req = 1'b1;
        busIf.pc_in = 16'h12F0;
        busIf.offset = 8'h20;
        tick();
        enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busIf.branch_req = 1'b0;
        flagModel = 2'b00;
        prevT = 16'h0000;
        chk("rstadd_target", {16'd0, busIf.target_pc}, 32'd0);
        chk("rstadd_busy", {31'd0, busIf.busy}, 32'd0);
        chk("rstadd_done", {31'd0, busIf.done}, 32'd0);
        chk("rstadd_cross", {31'd0, busIf.page_cross}, 32'd0);
        chk("rstadd_fwd", {31'd0, busIf.dir_fwd}, 32'd0);
        chk("rstadd_bwd", {31'd0, busIf.dir_bwd}, 32'd0);
        chk("rstadd_flags", {30'd0, flagOut}, 32'd0);
        tick();
        chk("post_rst_idle", {31'd0, busIf.busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] rp;
            logic [7:0]  ro;
            int          fl;
            rp = 16'($urandom);
            ro = 8'($urandom);
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            runBranch(rp, ro, fl, 1'($urandom), ($urandom_range(0, 4) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of captured flag channels (ch0 = forward, ch1 = backward by convention).
REQ-002 SHALL have parameter ADDR_W, default 16, program counter width; page = low 8 bits.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable_ffs  in  1  global hold; low freezes all state, including the FSM and flag bank.
REQ-006 SHALL have port enable  in  1  flag-bank capture strobe.
REQ-007 SHALL have port flag_in  in  NUM_CH  flag values to capture.
REQ-008 SHALL have port flag_out  out  NUM_CH  registered flags.
REQ-009 SHALL have port branch_req  in  1  taken-branch request, sampled only in IDLE.
REQ-010 SHALL have port offset  in  8  two's-complement branch displacement.
REQ-011 SHALL have port pc_in  in  ADDR_W  PC of the following instruction.
REQ-012 SHALL have outputs target_pc (ADDR_W), busy, done, page_cross, dir_fwd and dir_bwd (all 1 bit except target_pc), all registered.

Function
REQ-013 SHALL update flag_out <= flag_in only when enable_ffs=1 and enable=1; otherwise flag_out SHALL hold.
REQ-014 SHALL implement the FSM states IDLE, ADD, FIX and DONE.
REQ-015 SHALL, in IDLE with branch_req=1 and enable_ffs=1, latch pc_in and offset and move to ADD.
REQ-016 SHALL, in ADD, compute {carry, lo} = pc_lo + offset (8-bit) and set dir_fwd = ~offset[7] and dir_bwd = offset[7]; offset 0 counts as forward.
REQ-017 SHALL set page_cross = carry when forward and ~carry when backward; target_pc low byte = lo.
REQ-018 SHALL, in ADD with no page cross, set target_pc high part = pc high part and go to DONE.
REQ-019 SHALL, in FIX, set the high part to high+1 (forward) or high-1 (backward), modulo 2^(ADDR_W-8), with no saturation, then go to DONE.
REQ-020 SHALL assert busy in ADD and FIX, and assert done only in DONE for exactly one cycle; DONE goes to IDLE unconditionally.
REQ-021 SHALL ignore branch_req in ADD, FIX and DONE; there is no queueing.
REQ-022 SHALL hold target_pc, page_cross, dir_fwd and dir_bwd until the next ADD.
REQ-023 SHALL give latency from a branch_req edge to done: 2 cycles without a page cross, 3 cycles with one (macro on).
REQ-024 SHALL, when enable_ffs=0 in any state, keep both the state and all registers unchanged; done stays asserted if it was frozen in DONE.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, force state to IDLE and all outputs to 0, overriding enable_ffs and any in-flight operation.
REQ-026 SHALL, after reset, take no request before the cycle following rst deassertion.

Configuration
REQ-027 SHALL use macro BRANCH_SEQ_PAGE_PENALTY_EN.
REQ-028 SHALL, with BRANCH_SEQ_PAGE_PENALTY_EN defined, route a page cross ADD->FIX->DONE (one extra cycle).
REQ-029 SHALL, without BRANCH_SEQ_PAGE_PENALTY_EN, apply the high-part correction in ADD and go ADD->DONE; FIX SHALL be unreachable, and page_cross is still reported.

Structure
REQ-030 SHALL place the FSM state enum (branch_state_t) and the page width constant PAGE_W=8 in shared package branch_pkg.
REQ-031 SHALL implement the flag bank as sub-module flag_bank, parametrised by NUM_CH, with ports clk, rst, enable, enable_ffs, d, q.

Verification
REQ-032 SHALL cover: pc_in=0x1234, offset=0x10 -> target_pc=0x1244, page_cross=0, dir_fwd=1, done 2 cycles after req.
REQ-033 SHALL cover: pc_in=0x12F0, offset=0x20 -> target_pc=0x1310, page_cross=1; done at +3 (macro on) or +2 (macro off).
REQ-034 SHALL cover: pc_in=0x1205, offset=0xF0 -> target_pc=0x11F5, dir_bwd=1, page_cross=1; and pc_in=0xFFF0, offset=0x20 -> target_pc=0x0010 (wrap).
REQ-035 SHALL cover: enable_ffs=0 for 3 cycles while in FIX -> state, busy and target_pc frozen; done arrives 3 cycles late.
REQ-036 SHALL cover: enable=1 with enable_ffs=0 -> flag_out unchanged; enable=1 with enable_ffs=1 and flag_in=2'b10 -> flag_out=2'b10 next cycle.
REQ-037 SHALL cover: rst=1 during ADD -> next cycle IDLE with all outputs 0; branch_req during busy -> ignored, no second done.
